// File: rtl/mlkem_pkg.sv
// Shared constants and FSM state encoding for the ML-KEM rejection sampler.
package mlkem_pkg;

    localparam int MLKEM_Q             = 3329;
    localparam int MLKEM_N             = 256;
    localparam int SHAKE128_RATE_BYTES = 168;
    localparam int SQ_WORDS_PER_BLOCK  = 11;
    localparam int BUF_BYTES           = 18;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        PARSE,
        FLUSH
    } state_e;

endpackage

// File: rtl/mlkem_byte_fifo.sv
// Byte buffer for the rejection sampler: 18 bytes, head at byte 0.
// Pushes 16 bytes (or the low 8) at the current fill level, pops 3 from the head.
module mlkem_byte_fifo
    import mlkem_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         push_half_i,
    input  logic [127:0] push_data_i,
    input  logic         pop_i,
    output logic [23:0]  head_o,
    output logic [4:0]   count_o
);

    logic [BUF_BYTES*8-1:0] buf_q, buf_d;
    logic [BUF_BYTES*8-1:0] push_ext;
    logic [4:0]             cnt_q, cnt_d;

    // Next-state: clear, pop (shift down 3 bytes) or append at the fill level.
    // Bytes above the fill level are always zero, so appending is an OR.
    always_comb begin
        push_ext = {16'h0000, push_data_i};
        if (push_half_i) begin
            push_ext[127:64] = '0;
        end
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (pop_i) begin
            buf_d = buf_q >> 24;
            cnt_d = cnt_q - 5'd3;
        end else if (push_i) begin
            buf_d = buf_q | (push_ext << {cnt_q, 3'b000});
            cnt_d = cnt_q + (push_half_i ? 5'd8 : 5'd16);
        end
    end

    // Buffer and fill-level registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = buf_q[23:0];
    assign count_o = cnt_q;

endmodule

// File: rtl/mlkem_rej_sampler.sv
// ML-KEM uniform rejection sampler: parses SHAKE128 squeeze words into
// 12-bit candidates and emits the first N_COEFF candidates below Q.
// Optional feature: define MLKEM_REJ_SAMPLER_STATS_EN to enable the
// saturating per-polynomial rejected-candidate counter on o_rej_cnt.
module mlkem_rej_sampler
    import mlkem_pkg::*;
#(
    parameter int Q       = MLKEM_Q,
    parameter int N_COEFF = MLKEM_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_sq_data,
    input  logic         i_sq_valid,
    output logic         o_sq_ack,
    output logic [11:0]  o_coeff,
    output logic [7:0]   o_coeff_idx,
    output logic         o_coeff_valid,
    input  logic         i_coeff_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic [9:0]   o_rej_cnt
);

    localparam logic [12:0] Q_L       = 13'(Q);
    localparam logic [8:0]  LAST_ACC  = 9'(N_COEFF - 1);
    localparam logic [3:0]  LAST_WORD = 4'(SQ_WORDS_PER_BLOCK - 1);

    state_e      state_q;
    logic [3:0]  wcnt_q;
    logic [8:0]  nacc_q;
    logic        phase_q;
    logic        hold_q;
    logic        vld_q;
    logic        ack_q;
    logic        done_q;
    logic [11:0] coeff_q;
    logic [7:0]  idx_q;

    logic [23:0] head;
    logic [4:0]  fifo_cnt;
    logic        fifo_clr, fifo_push, fifo_pop;
    logic [11:0] cand;
    logic        accept, have_triple, can_load, parse_eval, hs, start_ok;

    assign start_ok    = (state_q == IDLE) && i_start;
    assign have_triple = fifo_cnt >= 5'd3;
    assign can_load    = !vld_q || i_coeff_ready;
    assign parse_eval  = (state_q == PARSE) && have_triple && can_load;
    // phase 0: d1 = b0 + 256*(b1 mod 16); phase 1: d2 = b1/16 + 16*b2
    assign cand        = phase_q ? {head[23:16], head[15:12]} : {head[11:8], head[7:0]};
    assign accept      = {1'b0, cand} < Q_L;
    assign hs          = vld_q && i_coeff_ready;
    assign fifo_clr    = start_ok || (state_q == FLUSH);
    assign fifo_push   = (state_q == FETCH) && i_sq_valid;
    assign fifo_pop    = parse_eval && phase_q;

    mlkem_byte_fifo u_fifo (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .clr_i       (fifo_clr),
        .push_i      (fifo_push),
        .push_half_i (wcnt_q == LAST_WORD),
        .push_data_i (i_sq_data),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    // Control FSM with registered handshake, coefficient and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            nacc_q  <= '0;
            phase_q <= 1'b0;
            hold_q  <= 1'b0;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            coeff_q <= '0;
            idx_q   <= '0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            if (hs) begin
                vld_q <= 1'b0;
                // the final handshake leaves the index on the last coefficient
                if (state_q != FLUSH) begin
                    idx_q <= idx_q + 8'd1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= FETCH;
                        wcnt_q  <= '0;
                        nacc_q  <= '0;
                        phase_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                FETCH: begin
                    if (i_sq_valid) begin
                        ack_q   <= 1'b1;
                        wcnt_q  <= (wcnt_q == LAST_WORD) ? 4'd0 : wcnt_q + 4'd1;
                        hold_q  <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // two dead cycles so the upstream squeeze register can advance
                    if (!hold_q) begin
                        hold_q <= 1'b1;
                    end else begin
                        state_q <= PARSE;
                    end
                end
                PARSE: begin
                    if (!have_triple) begin
                        state_q <= FETCH;
                    end else if (can_load) begin
                        phase_q <= ~phase_q;
                        if (accept) begin
                            coeff_q <= cand;
                            vld_q   <= 1'b1;
                            nacc_q  <= nacc_q + 9'd1;
                            if (nacc_q == LAST_ACC) begin
                                state_q <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (hs) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MLKEM_REJ_SAMPLER_STATS_EN
    logic [9:0] rej_q;

    // Saturating count of rejected candidates for the current polynomial.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            rej_q <= '0;
        end else if (parse_eval && !accept && (rej_q != 10'h3FF)) begin
            rej_q <= rej_q + 10'd1;
        end
    end

    assign o_rej_cnt = rej_q;
`else
    assign o_rej_cnt = '0;
`endif

    assign o_sq_ack      = ack_q;
    assign o_coeff       = coeff_q;
    assign o_coeff_idx   = idx_q;
    assign o_coeff_valid = vld_q;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;

endmodule

// File: tb/tb_mlkem_rej_sampler.sv
// Self-checking bench for mlkem_rej_sampler: a byte-stream reference model
// fills a queue of expected coefficients as squeeze words are consumed.
`timescale 1ns/1ps
module tb_mlkem_rej_sampler;

    localparam int Q     = 3329;
    localparam int M_INC = 0;
    localparam int M_RND = 1;
    localparam int M_FF  = 2;
    localparam int M_BND = 3;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [127:0] i_sq_data;
    logic         i_sq_valid;
    logic         o_sq_ack;
    logic [11:0]  o_coeff;
    logic [7:0]   o_coeff_idx;
    logic         o_coeff_valid;
    logic         i_coeff_ready;
    logic         o_busy;
    logic         o_done;
    logic [9:0]   o_rej_cnt;

    mlkem_rej_sampler dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_sq_data     (i_sq_data),
        .i_sq_valid    (i_sq_valid),
        .o_sq_ack      (o_sq_ack),
        .o_coeff       (o_coeff),
        .o_coeff_idx   (o_coeff_idx),
        .o_coeff_valid (o_coeff_valid),
        .i_coeff_ready (i_coeff_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_rej_cnt     (o_rej_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]   mq[$];
    logic [11:0]  exq[$];
    int           exp_n, exp_rej, wk, mode;
    logic [127:0] cur_word;
    bit           rnd_rdy = 1'b0;
    int           low_cnt = 0;
    bit           pulse_start = 1'b0;

    // per-cycle observations
    bit           ob_ack, ob_done, ob_hs, ob_full_before;
    logic [11:0]  ob_coeff;
    logic [7:0]   ob_idx;
    logic [11:0]  first_co [0:2];
    logic [9:0]   rej_at2;

    function automatic logic [127:0] gen_word(input int k);
        logic [127:0] w;
        case (mode)
            M_INC:   for (int j = 0; j < 16; j++) w[j*8 +: 8] = 8'((k*16 + j + 1) & 255);
            M_FF:    w = '1;
            default: w = {$urandom, $urandom, $urandom, $urandom};
        endcase
        if (mode == M_BND && k == 0) w[47:0] = 48'h000D01000D00;
        if (k % 11 == 10) w[127:64] = {8{8'h01}};
        return w;
    endfunction

    task automatic model_cand(input logic [11:0] d);
        if (exp_n < 256) begin
            if (d < Q) begin
                exq.push_back(d);
                exp_n++;
            end else if (exp_rej < 1023) begin
                exp_rej++;
            end
        end
    endtask

    task automatic model_push(input logic [127:0] w, input int k);
        int nb;
        logic [7:0] b0, b1, b2;
        nb = (k % 11 == 10) ? 8 : 16;
        for (int j = 0; j < nb; j++) mq.push_back(w[j*8 +: 8]);
        while (mq.size() >= 3) begin
            b0 = mq.pop_front();
            b1 = mq.pop_front();
            b2 = mq.pop_front();
            model_cand({b1[3:0], b0});
            model_cand({b2, b1[7:4]});
        end
    endtask

    // One cycle: observe past ack/done, advance upstream, drive ready, observe handshake.
    task automatic tick();
        @(negedge i_clk);
        ob_ack = o_sq_ack;
        ob_done = o_done;
        ob_full_before = (exp_n >= 256);
        if (o_sq_ack) begin
            model_push(cur_word, wk);
            wk++;
            cur_word = gen_word(wk);
            i_sq_data = cur_word;
        end
        i_start = pulse_start;
        pulse_start = 1'b0;
        i_sq_valid = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (low_cnt > 0) begin
            i_coeff_ready = 1'b0;
            low_cnt--;
        end else begin
            i_coeff_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        ob_hs = o_coeff_valid && i_coeff_ready;
        ob_coeff = o_coeff;
        ob_idx = o_coeff_idx;
    endtask

    task automatic start_poly(input int m, input bit rr);
        mode = m;
        rnd_rdy = rr;
        mq.delete();
        exq.delete();
        exp_n = 0;
        exp_rej = 0;
        wk = 0;
        low_cnt = 0;
        cur_word = gen_word(0);
        i_sq_data = cur_word;
        i_sq_valid = 1'b1;
        pulse_start = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_start = 1'b0;
        i_sq_valid = 1'b0;
        i_sq_data = '0;
        i_coeff_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_sq_ack, o_coeff_valid, o_busy, o_done} !== 4'b0 || o_coeff !== 12'd0 ||
            o_coeff_idx !== 8'd0 || o_rej_cnt !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b vld=%b busy=%b done=%b coeff=%0d idx=%0d rej=%0d want all 0",
                     o_sq_ack, o_coeff_valid, o_busy, o_done, o_coeff, o_coeff_idx, o_rej_cnt);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_coeff_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b vld=%b want 0 0", o_busy, o_coeff_valid);
        end
    endtask

    // Runs one polynomial against the scoreboard; optional ready-hold window,
    // ignored mid-stream start pulse, or reset at a given coefficient index.
    task automatic test_full_poly(input int m, input bit rr, input int hold_at,
                                  input int rst_at, input int start_at);
        int hs_cnt, done_cnt, extra_ack;
        bit finished, armed, do_rst, st_have;
        logic [11:0] st_c, exp_c;
        logic [7:0] st_i;
        hs_cnt = 0; done_cnt = 0; extra_ack = 0;
        finished = 0; armed = 0; do_rst = 0; st_have = 0;
        start_poly(m, rr);
        tick();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", o_busy);
        end
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            tick();
            if (ob_ack) begin
                checks++;
                if (ob_full_before) begin
                    errors++;
                    $display("FAIL ack_after_full got ack=1 want 0 (word %0d)", wk);
                end
            end
            if (ob_hs) begin
                checks++;
                if (exq.size() == 0) begin
                    errors++;
                    $display("FAIL coeff_unexpected got %0d@%0d want none", ob_coeff, ob_idx);
                end else begin
                    exp_c = exq.pop_front();
                    if (ob_coeff !== exp_c || ob_idx !== hs_cnt[7:0]) begin
                        errors++;
                        $display("FAIL coeff got %0d@%0d want %0d@%0d", ob_coeff, ob_idx, exp_c, hs_cnt);
                    end
                end
                if (hs_cnt < 3) first_co[hs_cnt] = ob_coeff;
                if (hs_cnt == 2) rej_at2 = o_rej_cnt;
                hs_cnt++;
                if (start_at > 0 && hs_cnt == start_at) pulse_start = 1'b1;
                if (hold_at > 0 && hs_cnt == hold_at) armed = 1'b1;
                if (rst_at > 0 && ob_idx == 8'(rst_at)) do_rst = 1'b1;
            end
            if (armed && ob_ack) begin
                armed = 1'b0;
                low_cnt = 10;
                for (int h = 0; h < 10; h++) begin
                    tick();
                    checks++;
                    if (ob_ack) begin
                        errors++;
                        $display("FAIL hold_ack got ack=1 want 0 (cycle %0d)", h);
                    end
                    if (st_have) begin
                        checks++;
                        if (!o_coeff_valid || ob_coeff !== st_c || ob_idx !== st_i) begin
                            errors++;
                            $display("FAIL hold_stable got %0d@%0d vld=%b want %0d@%0d vld=1",
                                     ob_coeff, ob_idx, o_coeff_valid, st_c, st_i);
                        end
                    end else if (o_coeff_valid) begin
                        st_have = 1'b1;
                        st_c = ob_coeff;
                        st_i = ob_idx;
                    end
                end
                checks++;
                if (!st_have) begin
                    errors++;
                    $display("FAIL hold_valid got vld=0 want 1 during hold");
                end
            end
            if (ob_done) begin
                done_cnt++;
                finished = 1'b1;
                checks++;
                if (hs_cnt != 256) begin
                    errors++;
                    $display("FAIL done_early got %0d handshakes want 256", hs_cnt);
                end
            end
            if (do_rst) begin
                i_rst = 1'b1;
                @(negedge i_clk);
                checks++;
                if ({o_sq_ack, o_coeff_valid, o_busy, o_done} !== 4'b0 || o_coeff !== 12'd0 ||
                    o_coeff_idx !== 8'd0 || o_rej_cnt !== 10'd0) begin
                    errors++;
                    $display("FAIL reset_mid ack=%b vld=%b busy=%b done=%b coeff=%0d idx=%0d rej=%0d want all 0",
                             o_sq_ack, o_coeff_valid, o_busy, o_done, o_coeff, o_coeff_idx, o_rej_cnt);
                end
                i_rst = 1'b0;
                for (int p = 0; p < 40; p++) begin
                    tick();
                    checks++;
                    if (ob_ack || ob_done || o_busy) begin
                        errors++;
                        $display("FAIL after_reset got ack=%b done=%b busy=%b want 0 0 0", ob_ack, ob_done, o_busy);
                    end
                end
                return;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL timeout got no done want done (handshakes %0d)", hs_cnt);
        end
        checks++;
        if (hs_cnt != 256 || exq.size() != 0) begin
            errors++;
            $display("FAIL coeff_count got %0d want 256 (left %0d)", hs_cnt, exq.size());
        end
        for (int p = 0; p < 8; p++) begin
            tick();
            if (ob_done) done_cnt++;
            if (ob_ack) extra_ack++;
        end
        checks++;
        if (done_cnt != 1 || extra_ack != 0) begin
            errors++;
            $display("FAIL done_once got done=%0d acks=%0d want 1 0", done_cnt, extra_ack);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done got %b want 0", o_busy);
        end
        checks++;
`ifdef MLKEM_REJ_SAMPLER_STATS_EN
        if (o_rej_cnt !== 10'(exp_rej)) begin
            errors++;
            $display("FAIL rej_total got %0d want %0d", o_rej_cnt, exp_rej);
        end
`else
        if (o_rej_cnt !== 10'd0) begin
            errors++;
            $display("FAIL rej_const got %0d want 0", o_rej_cnt);
        end
`endif
    endtask

    task automatic test_first_word();
        test_full_poly(M_INC, 1'b0, 0, 0, 0);
        checks++;
        if (first_co[0] !== 12'd513 || first_co[1] !== 12'd48) begin
            errors++;
            $display("FAIL first_word got %0d,%0d want 513,48", first_co[0], first_co[1]);
        end
    endtask

    task automatic test_boundary();
        test_full_poly(M_BND, 1'b0, 0, 0, 0);
        checks++;
        if (first_co[0] !== 12'd3328 || first_co[1] !== 12'd0 || first_co[2] !== 12'd0) begin
            errors++;
            $display("FAIL boundary got %0d,%0d,%0d want 3328,0,0", first_co[0], first_co[1], first_co[2]);
        end
`ifdef MLKEM_REJ_SAMPLER_STATS_EN
        checks++;
        if (rej_at2 !== 10'd1) begin
            errors++;
            $display("FAIL boundary_rej got %0d want 1", rej_at2);
        end
`endif
    endtask

    task automatic test_backpressure();
        test_full_poly(M_RND, 1'b1, 60, 0, 30);
    endtask

    task automatic test_back_to_back();
        test_full_poly(M_RND, 1'b0, 0, 0, 0);
        test_full_poly(M_RND, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        test_full_poly(M_RND, 1'b1, 0, 100, 0);
        test_full_poly(M_RND, 1'b0, 0, 0, 0);
    endtask

    task automatic test_all_ff();
        int acks, vlds;
        acks = 0;
        vlds = 0;
        start_poly(M_FF, 1'b0);
        for (int c = 0; c < 2500; c++) begin
            tick();
            if (ob_ack) acks++;
            if (o_coeff_valid) vlds++;
        end
        checks++;
        if (vlds != 0) begin
            errors++;
            $display("FAIL ff_no_coeff got %0d valid cycles want 0", vlds);
        end
        checks++;
        if (acks < 50 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ff_acks got %0d acks busy=%b want >=50 busy=1", acks, o_busy);
        end
        checks++;
`ifdef MLKEM_REJ_SAMPLER_STATS_EN
        if (o_rej_cnt !== 10'd1023) begin
            errors++;
            $display("FAIL ff_rej_sat got %0d want 1023", o_rej_cnt);
        end
`else
        if (o_rej_cnt !== 10'd0) begin
            errors++;
            $display("FAIL ff_rej_const got %0d want 0", o_rej_cnt);
        end
`endif
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_rej_cnt !== 10'd0 || o_busy !== 1'b0 || o_sq_ack !== 1'b0) begin
            errors++;
            $display("FAIL ff_reset got rej=%0d busy=%b ack=%b want 0 0 0", o_rej_cnt, o_busy, o_sq_ack);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_all_ff();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlkem_rej_sampler.md
MLKEM_REJ_SAMPLER -- requirements
Module: mlkem_rej_sampler

Interface
REQ-001 SHALL have parameter Q, default 3329: modulus; candidates below Q are accepted.
REQ-002 SHALL have parameter N_COEFF, default 256: coefficients per polynomial.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1: one-cycle pulse that begins sampling one polynomial.
REQ-006 SHALL have port i_sq_data, input, 128: SHAKE128 squeeze word; little-endian bytes, byte 0 = bits [7:0].
REQ-007 SHALL have port i_sq_valid, input, 1: i_sq_data valid.
REQ-008 SHALL have port o_sq_ack, output, 1: one-cycle pulse; squeeze word consumed.
REQ-009 SHALL have port o_coeff, output, 12: accepted coefficient.
REQ-010 SHALL have port o_coeff_idx, output, 8: coefficient index, 0..255.
REQ-011 SHALL have port o_coeff_valid, output, 1: o_coeff and o_coeff_idx valid.
REQ-012 SHALL have port i_coeff_ready, input, 1: consumer accepts the coefficient when high with o_coeff_valid.
REQ-013 SHALL have port o_busy, output, 1: polynomial in progress.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse after the last coefficient handshake.
REQ-015 SHALL have port o_rej_cnt, output, 10: rejected-candidate count; see Configuration.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD, PARSE and FLUSH.
REQ-017 IDLE→FETCH SHALL occur on i_start; this clears the byte buffer, the word counter (0..10) and the coefficient counter; i_start outside IDLE SHALL be ignored.
REQ-018 FETCH SHALL wait for i_sq_valid, then append 16 bytes to the buffer when the word counter is 0..9, or only the low 8 bytes (bits [63:0]) when it is 10; upper bits of word 10 SHALL be discarded.
REQ-019 The cycle a word is captured SHALL assert o_sq_ack for exactly one cycle, advance the word counter mod 11, and go to HOLD.
REQ-020 HOLD SHALL last exactly 2 cycles with i_sq_valid and i_sq_data ignored, so the upstream registered output settles; it SHALL then go to PARSE.
REQ-021 PARSE SHALL, while at least 3 bytes are buffered, pop bytes b0, b1, b2 and form candidate d1 = b0 + 256*(b1 mod 16) and candidate d2 = floor(b1/16) + 16*b2, evaluating d1 then d2 at one candidate per cycle.
REQ-022 A candidate below Q SHALL load the output register; a candidate of Q or above SHALL be dropped.
REQ-023 With fewer than 3 bytes buffered, PARSE SHALL return to FETCH and keep 0-2 residual bytes; the buffer SHALL hold at most 18 bytes.
REQ-024 Each 168-byte block SHALL yield exactly 56 byte triples; no triple spans a block boundary.
REQ-025 The output register SHALL hold o_coeff and o_coeff_idx stable while o_coeff_valid=1 and i_coeff_ready=0.
REQ-026 PARSE SHALL stall while the output register is full, except in a cycle where i_coeff_ready=1, when the register SHALL reload with zero bubbles.
REQ-027 After the 256th accepted candidate, all remaining candidates and buffered bytes SHALL be discarded and no further o_sq_ack issued; FLUSH SHALL wait for the final handshake, pulse o_done, and return to IDLE.
REQ-028 o_coeff_idx SHALL increment on each output handshake and never wrap within a polynomial.
REQ-029 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-030 i_rst SHALL place the FSM in IDLE and clear the buffer, all counters and o_rej_cnt.
REQ-031 Under i_rst, o_sq_ack, o_coeff_valid, o_busy and o_done SHALL be 0, and o_coeff and o_coeff_idx SHALL be 0.
REQ-032 Reset asserted mid-polynomial SHALL abort with no o_done pulse and no further o_sq_ack.

Configuration
REQ-033 With macro MLKEM_REJ_SAMPLER_STATS_EN defined, o_rej_cnt SHALL count rejected candidates for the current polynomial, clear on i_start, and saturate at 1023.
REQ-034 Without MLKEM_REJ_SAMPLER_STATS_EN, o_rej_cnt SHALL be constant 0 and no counter logic SHALL be present.

Structure
REQ-035 Package mlkem_pkg SHALL hold MLKEM_Q=3329, MLKEM_N=256, SHAKE128_RATE_BYTES=168, SQ_WORDS_PER_BLOCK=11 and the FSM state enum.
REQ-036 One sub-module, mlkem_byte_fifo (18-byte buffer: push 8 or 16 bytes, pop 3), SHALL be used; the candidate compare SHALL stay in the top.

Verification
REQ-037 First word bytes 01 02 03 …, consumer ready → o_coeff=513 at idx 0, then 48 at idx 1.
REQ-038 Triple 00 0D 00 → 3328 accepted; triple 01 0D 00 → 3329 rejected; with STATS_EN, o_rej_cnt increments by 1 for the rejection.
REQ-039 All bytes FF → no coefficients, o_sq_ack continues indefinitely; with STATS_EN, o_rej_cnt saturates at 1023.
REQ-040 Word 10 with upper 64 bits = all 01 → those bytes never appear in any coefficient; the next triple starts at byte 0 of the following word.
REQ-041 i_coeff_ready held low for 10 cycles mid-stream → o_coeff stable, no o_sq_ack; after release, the full 256-coefficient sequence matches the reference model and o_done pulses once.
REQ-042 i_rst asserted at coefficient 100 → outputs 0 the next cycle, no o_done; a subsequent i_start restarts at idx 0.
